// File: rtl/cla_word_sequencer.sv
// Sequences an NWORDS*W-bit add through one W-bit carry-lookahead slice, LS word first.
// Latency: done pulses NWORDS+1 edges after the accepting edge; issue interval NWORDS+2.
// Backpressure: start is taken only in IDLE; requests while busy are dropped, not queued.
module cla_word_sequencer #(
    parameter int W      = 4,
    parameter int NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W*NWORDS-1:0]   a,
    input  logic [W*NWORDS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [W*NWORDS-1:0]   sum,
    output logic                  cout
);

    localparam int N  = W * NWORDS;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;

    logic [W-1:0]  a_w;
    logic [W-1:0]  b_w;
    logic [W-1:0]  s_w;
    logic          c_w;

    assign a_w = a_r[W*int'(idx) +: W];
    assign b_w = b_r[W*int'(idx) +: W];

    // Each slice carry is the flattened OR of generate terms gated by the
    // propagate chain above them, so no carry depends on a lower slice carry.
    always_comb begin : cla
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W:0]   c;
        logic         term;
        logic         pp;
        g    = a_w & b_w;
        p    = a_w ^ b_w;
        c    = '0;
        term = 1'b0;
        pp   = 1'b0;
        c[0] = carry;
        for (int i = 0; i < W; i++) begin
            term = g[i];
            pp   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[i+1] = term | (pp & carry);
        end
        s_w = p ^ c[W-1:0];
        c_w = c[W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // Status flags trail the state by one edge so done lines up with
            // the final busy cycle and the result already sitting in sum.
            busy <= (state != IDLE);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[W*int'(idx) +: W] <= s_w;
                    carry <= c_w;
                    if (idx == LAST) begin
                        cout  <= c_w;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed and random checks of cla_word_sequencer against a cycle-accurate timing/arith model.
module tb_cla_word_sequencer;

    localparam int NW = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, cin;
    logic [15:0] a, b, sum;
    logic        busy, done, cout;

    logic        start1, cin1;
    logic [7:0]  a1, b1, sum1;
    logic        busy1, done1, cout1;

    int errors = 0;
    int checks = 0;

    cla_word_sequencer #(.W(4), .NWORDS(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    cla_word_sequencer #(.W(8), .NWORDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model of u0: edge counter, edge index of the last accepted start, and
    // the arithmetic result that becomes visible once the last word is written.
    int          cyc;
    int          t0;
    logic [15:0] pend_s, exp_s;
    logic        pend_c, exp_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc   = 0;
            t0    = -100;
            exp_s = '0;
            exp_c = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (start && cyc >= t0 + NW + 2) begin
                t0 = cyc;
                {pend_c, pend_s} = {1'b0, a} + {1'b0, b} + 17'(cin);
            end
            if (cyc == t0 + NW) begin
                exp_s = pend_s;
                exp_c = pend_c;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_busy", 32'(busy), 32'(cyc >= t0 + 1 && cyc <= t0 + NW + 1));
            chk("model_done", 32'(done), 32'(cyc == t0 + NW + 1));
            if (cyc <= t0 || cyc >= t0 + NW) begin
                chk("model_sum", 32'(sum), 32'(exp_s));
                chk("model_cout", 32'(cout), 32'(exp_c));
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                          input bit inject, output int lat, output int bcnt);
        @(posedge clk); #2;
        start = 1'b1; a = ta; b = tbv; cin = tc;
        @(posedge clk); #2;
        start = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done && lat < 0) lat = i - 1;
            if (inject && i == 2) begin start = 1'b1; a = 16'hAAAA; end
            if (inject && i == 3) start = 1'b0;
        end
        if (lat < 0) chk("done_timeout", 32'(lat), 32'd5);
    endtask

    task automatic run_op1(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                           output int lat);
        @(posedge clk); #2;
        start1 = 1'b1; a1 = ta; b1 = tbv; cin1 = tc;
        @(posedge clk); #2;
        start1 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (done1 && lat < 0) lat = i - 1;
        end
        if (lat < 0) chk("done1_timeout", 32'(lat), 32'd2);
    endtask

    initial begin
        int lat, bcnt;
        int dpos[$];
        logic [15:0] ra, rb;
        logic        rc;
        logic [7:0]  ra1, rb1;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #23;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_sum1", 32'(sum1), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // 1: full carry ripple through every word
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcnt);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_busy_cycles", 32'(bcnt), 32'd5);
        chk("t1_sum", 32'(sum), 32'h0000);
        chk("t1_cout", 32'(cout), 32'd1);

        // 2: carry-in, then result holds in IDLE
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat, bcnt);
        chk("t2_sum", 32'(sum), 32'h5556);
        chk("t2_cout", 32'(cout), 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_hold_sum", 32'(sum), 32'h5556);

        // 3: start during RUN is ignored
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, lat, bcnt);
        chk("t3_sum", 32'(sum), 32'h0100);
        chk("t3_cout", 32'(cout), 32'd0);

        // 4: start held high, operands alternate after each done
        @(posedge clk); #2;
        start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        for (int i = 1; i <= 40 && dpos.size() < 4; i++) begin
            @(negedge clk);
            if (done) begin
                dpos.push_back(i);
                if (dpos.size() == 4) start = 1'b0;
                else if (dpos.size() % 2 == 1) begin a = 16'hF0F0; b = 16'h0F10; cin = 1'b1; end
                else begin a = 16'h1111; b = 16'h2222; cin = 1'b0; end
            end
        end
        chk("t4_done_count", 32'(dpos.size()), 32'd4);
        if (dpos.size() == 4) begin
            for (int k = 1; k < 4; k++) chk("t4_interval", 32'(dpos[k] - dpos[k-1]), 32'd6);
        end
        chk("t4_sum", 32'(sum), 32'h0001);
        chk("t4_cout", 32'(cout), 32'd1);
        repeat (4) @(negedge clk);

        // 5: reset mid-RUN with idx=2
        @(posedge clk); #2;
        start = 1'b1; a = 16'h0123; b = 16'h0111; cin = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_sum",  32'(sum),  32'd0);
        chk("t5_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(16'h0123, 16'h0111, 1'b0, 1'b0, lat, bcnt);
        chk("t5_after_latency", 32'(lat), 32'd5);
        chk("t5_after_sum", 32'(sum), 32'h0234);

        // 6: single-word instance
        run_op1(8'h80, 8'h80, 1'b1, lat);
        chk("t6_latency", 32'(lat), 32'd2);
        chk("t6_sum", 32'(sum1), 32'h01);
        chk("t6_cout", 32'(cout1), 32'd1);

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            run_op(ra, rb, rc, 1'b0, lat, bcnt);
            chk("rand_result", 32'({cout, sum}), 32'({1'b0, ra} + {1'b0, rb} + 17'(rc)));
        end
        for (int n = 0; n < 200; n++) begin
            ra1 = 8'($urandom); rb1 = 8'($urandom); rc = 1'($urandom);
            run_op1(ra1, rb1, rc, lat);
            chk("rand1_result", 32'({cout1, sum1}), 32'({1'b0, ra1} + {1'b0, rb1} + 9'(rc)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
